soc_sysid_checker: RTL
======================

SOC_SYSID_CHECKER -- requirements
Module: soc_sysid_checker

Interface
REQ-001: The block SHALL have these parameters, one per line as name, default, meaning:
- EXPECTED_ID, 32'h0000_0000, system ID value the slave must return at address 0.
- TIMEOUT_CYCLES, 255, maximum consecutive waitrequest-high cycles tolerated per read (1..65535).
- MAX_RETRIES, 3, maximum re-issues of a timed-out read (1..15; used only with the macro).
REQ-002: The block SHALL have these ports, one per line as name, direction, width, meaning:
- clock, in, 1, single clock for all logic.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, one-cycle pulse that begins a check; ignored while busy=1.
- avm_address, out, 1, Avalon-MM word address (0 = ID, 1 = timestamp).
- avm_read, out, 1, Avalon-MM read strobe.
- avm_readdata, in, 32, Avalon-MM read data.
- avm_waitrequest, in, 1, slave stall; the read completes in the first cycle with avm_read=1 and waitrequest=0.
- busy, out, 1, check in progress.
- done, out, 1, one-cycle pulse when a check finishes.
- id_match, out, 1, captured ID equals EXPECTED_ID.
- id_value, out, 32, captured ID word.
- timestamp, out, 32, captured timestamp word.
- timeout_err, out, 1, a read was abandoned.

Function
REQ-003: The FSM SHALL have the states IDLE, RD_ID, RD_TS, CHECK and FIN.
REQ-004: IDLE SHALL go to RD_ID on start=1, and on the next cycle drive avm_read=1, avm_address=0 and busy=1.
REQ-005: In RD_ID and RD_TS, avm_read and avm_address SHALL stay stable while avm_waitrequest=1.
REQ-006: On completion, RD_ID SHALL capture avm_readdata into id_value and go to RD_TS (avm_address=1); RD_TS SHALL capture into timestamp and go to CHECK.
REQ-007: avm_read SHALL be 0 for at least one cycle between the two reads (0-cycle gap not permitted).
REQ-008: CHECK SHALL register id_match = (id_value == EXPECTED_ID) in one cycle, then go to FIN.
REQ-009: FIN SHALL assert done=1 for exactly one cycle, deassert busy and return to IDLE.
REQ-010: Minimum latency from the start pulse to done with waitrequest always 0 SHALL be 6 cycles.
REQ-011: A 16-bit wait counter SHALL clear on each read issue and increment on each cycle with waitrequest=1.
REQ-012: When the wait counter reaches TIMEOUT_CYCLES, the read SHALL time out: avm_read drops for one cycle, and the handling is as given in Configuration.
REQ-013: On timeout abandonment, timeout_err=1, id_match=0, and uncaptured data registers SHALL keep their previous values.
REQ-014: A start pulse while busy=1 SHALL be ignored; start in the same cycle as done SHALL be ignored.
REQ-015: id_value, timestamp, id_match and timeout_err SHALL hold until the next start is accepted; timeout_err SHALL clear on accept.

Reset
REQ-016: reset=1 SHALL force IDLE on the next clock edge, with outputs avm_read=0, avm_address=0, busy=0, done=0, id_match=0, timeout_err=0, id_value=0, timestamp=0, and counters at 0.
REQ-017: reset asserted mid-read SHALL abort immediately, with no done pulse; reset SHALL take priority over start.

Configuration
REQ-018: The macro SYSID_CHECKER_RETRY_EN SHALL select the timeout handling.
- Defined: a timed-out read SHALL be re-issued (same address) after the one-cycle gap, up to MAX_RETRIES times; a retry counter clears per read; exhausting retries abandons the read (REQ-013) and goes to FIN.
- Undefined: the first timeout SHALL abandon the read and go to FIN; no retry counter is synthesized.

Verification
REQ-019: Slave returns ID 0, timestamp 1648570666, waitrequest=0, EXPECTED_ID=0, start pulse -> done 6 cycles later, id_match=1, timestamp=1648570666, timeout_err=0.
REQ-020: EXPECTED_ID=32'h1234_5678, slave ID 0 -> done, id_match=0, id_value=0.
REQ-021: waitrequest high for 10 cycles on each read, TIMEOUT_CYCLES=255 -> address held stable, done at cycle 26, correct data.
REQ-022: waitrequest stuck high, TIMEOUT_CYCLES=8 -> macro undefined: done after the first timeout with timeout_err=1; macro defined, MAX_RETRIES=3: exactly 4 read issues on address 0, then done with timeout_err=1.
REQ-023: reset pulsed during RD_TS -> next cycle IDLE, avm_read=0, all outputs 0, no done pulse; a later start completes normally.
REQ-024: start pulsed during busy and again in the done cycle -> both ignored, exactly one done.

Source files
------------

// File: rtl/soc_sysid_checker.sv
// Avalon-MM system-ID checker: reads the ID word (address 0), then the timestamp
// (address 1), and compares the ID against EXPECTED_ID. Optional macro: SYSID_CHECKER_RETRY_EN.
module soc_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_match,
    output logic [31:0] id_value,
    output logic [31:0] timestamp,
    output logic        timeout_err
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD_ID = 3'd1;
    localparam logic [2:0] ST_RD_TS = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT_CYCLES - 1);

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535) ||
        (MAX_RETRIES < 1) || (MAX_RETRIES > 15)) begin : g_bad_param
        $error("soc_sysid_checker: parameter out of range");
    end

    logic [2:0]  state_q, state_d;
    logic        avm_read_q, avm_read_d;
    logic        avm_addr_q, avm_addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        id_match_q, id_match_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] timestamp_q, timestamp_d;
    logic        timeout_err_q, timeout_err_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
`ifdef SYSID_CHECKER_RETRY_EN
    localparam logic [3:0] RETRY_LIM = 4'(MAX_RETRIES);
    logic [3:0]  retry_cnt_q, retry_cnt_d;
`endif

    // Next-state and output-register computation for the read sequencer.
    always_comb begin
        state_d       = state_q;
        avm_read_d    = avm_read_q;
        avm_addr_d    = avm_addr_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        id_match_d    = id_match_q;
        id_value_d    = id_value_q;
        timestamp_d   = timestamp_q;
        timeout_err_d = timeout_err_q;
        wait_cnt_d    = wait_cnt_q;
`ifdef SYSID_CHECKER_RETRY_EN
        retry_cnt_d   = retry_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // done_q marks the completion cycle, in which a new start is refused
                if (start && !done_q) begin
                    state_d       = ST_RD_ID;
                    avm_read_d    = 1'b1;
                    avm_addr_d    = 1'b0;
                    busy_d        = 1'b1;
                    timeout_err_d = 1'b0;
                    wait_cnt_d    = 16'd0;
`ifdef SYSID_CHECKER_RETRY_EN
                    retry_cnt_d   = 4'd0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_ID, ST_RD_TS: begin
                if (!avm_read_q) begin
                    avm_read_d = 1'b1;
                    wait_cnt_d = 16'd0;
                end else if (!avm_waitrequest) begin
                    avm_read_d = 1'b0;
                    wait_cnt_d = 16'd0;
`ifdef SYSID_CHECKER_RETRY_EN
                    retry_cnt_d = 4'd0;
`endif
                    if (state_q == ST_RD_ID) begin
                        id_value_d = avm_readdata;
                        avm_addr_d = 1'b1;
                        state_d    = ST_RD_TS;
                    end else begin
                        timestamp_d = avm_readdata;
                        state_d     = ST_CHECK;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    avm_read_d = 1'b0;
                    wait_cnt_d = WAIT_LIMIT;
`ifdef SYSID_CHECKER_RETRY_EN
                    if (retry_cnt_q < RETRY_LIM) begin
                        retry_cnt_d = retry_cnt_q + 4'd1;
                    end else begin
                        state_d       = ST_FIN;
                        timeout_err_d = 1'b1;
                        id_match_d    = 1'b0;
                    end
`else
                    state_d       = ST_FIN;
                    timeout_err_d = 1'b1;
                    id_match_d    = 1'b0;
`endif
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            ST_CHECK: begin
                id_match_d = (id_value_q == EXPECTED_ID);
                state_d    = ST_FIN;
            end
            ST_FIN: begin
                done_d     = 1'b1;
                busy_d     = 1'b0;
                avm_read_d = 1'b0;
                avm_addr_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                avm_read_d = 1'b0;
                avm_addr_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            avm_read_q    <= 1'b0;
            avm_addr_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            id_match_q    <= 1'b0;
            id_value_q    <= 32'd0;
            timestamp_q   <= 32'd0;
            timeout_err_q <= 1'b0;
            wait_cnt_q    <= 16'd0;
`ifdef SYSID_CHECKER_RETRY_EN
            retry_cnt_q   <= 4'd0;
`endif
        end else begin
            state_q       <= state_d;
            avm_read_q    <= avm_read_d;
            avm_addr_q    <= avm_addr_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            id_match_q    <= id_match_d;
            id_value_q    <= id_value_d;
            timestamp_q   <= timestamp_d;
            timeout_err_q <= timeout_err_d;
            wait_cnt_q    <= wait_cnt_d;
`ifdef SYSID_CHECKER_RETRY_EN
            retry_cnt_q   <= retry_cnt_d;
`endif
        end
    end

    assign avm_address = avm_addr_q;
    assign avm_read    = avm_read_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign id_match    = id_match_q;
    assign id_value    = id_value_q;
    assign timestamp   = timestamp_q;
    assign timeout_err = timeout_err_q;

endmodule
